// File: rtl/neuron_core_bus_ctrl_pkg.sv
// Shared definitions for the neuron core bus controller: region codes, FSM
// encoding and default geometry.
package neuron_core_bus_ctrl_pkg;

    localparam logic [16:0] BASE_HI_DEF     = 17'h6000;
    localparam int          SYN_AW_DEF      = 8;
    localparam int          N_PARAM_DEF     = 3;
    localparam int          PARAM_START_BIT = 0;

    typedef enum logic [1:0] {
        REGION_SYN      = 2'd0,
        REGION_PARAM    = 2'd1,
        REGION_SPIKE    = 2'd2,
        REGION_UNMAPPED = 2'd3
    } region_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RAM  = 2'd1,
        ST_ACK  = 2'd2
    } state_e;

endpackage

// File: rtl/neuron_core_bus_ctrl_addr_dec.sv
// Combinational region decode of the core's 32 KB Wishbone window.
module neuron_core_bus_ctrl_addr_dec
    import neuron_core_bus_ctrl_pkg::*;
#(
    parameter logic [16:0] BASE_HI = BASE_HI_DEF,
    parameter int          SYN_AW  = SYN_AW_DEF,
    parameter int          N_PARAM = N_PARAM_DEF
) (
    input  logic [31:0]       adr,
    output region_e           region,
    output logic [SYN_AW-1:0] syn_word,
    output logic [1:0]        param_idx
);

    logic unused_byte_bits;
    assign unused_byte_bits = ^adr[1:0];

    // NOTE: every signal written in always_comb gets a default first, so no path infers a latch.
    always_comb begin
        region = REGION_UNMAPPED;
        if (adr[31:15] == BASE_HI) begin
            case (adr[14:13])
                2'b00: if (adr[12:SYN_AW+2] == '0) region = REGION_SYN;
                2'b01: if (adr[12:4] == '0 && 32'(adr[3:2]) < N_PARAM) region = REGION_PARAM;
                2'b10: if (adr[12:2] == '0) region = REGION_SPIKE;
                default: region = REGION_UNMAPPED;
            endcase
        end
    end

    assign syn_word  = adr[SYN_AW+1:2];
    assign param_idx = adr[3:2];

endmodule

// File: rtl/neuron_core_bus_ctrl.sv
// Wishbone slave for one neuron core: sequences synapse RAM accesses, holds the
// parameter file, pulses core start and captures spikes in a read-to-clear register.
module neuron_core_bus_ctrl
    import neuron_core_bus_ctrl_pkg::*;
#(
    parameter logic [16:0] BASE_HI = BASE_HI_DEF,
    parameter int          SYN_AW  = SYN_AW_DEF,
    parameter int          N_PARAM = N_PARAM_DEF
) (
    input  logic                   wb_clk_i,
    input  logic                   wb_rst_i,
    input  logic                   wbs_cyc_i,
    input  logic                   wbs_stb_i,
    input  logic                   wbs_we_i,
    input  logic [3:0]             wbs_sel_i,
    input  logic [31:0]            wbs_adr_i,
    input  logic [31:0]            wbs_dat_i,
    output logic                   wbs_ack_o,
    output logic [31:0]            wbs_dat_o,
    output logic                   ram_en_o,
    output logic [3:0]             ram_we_o,
    output logic [SYN_AW-1:0]      ram_a_o,
    output logic [31:0]            ram_di_o,
    input  logic [31:0]            ram_do_i,
    input  logic                   core_busy_i,
    input  logic                   core_rd_i,
    input  logic [SYN_AW-1:0]      core_addr_i,
    output logic [32*N_PARAM-1:0]  param_o,
    output logic                   core_start_o,
    input  logic [31:0]            spike_i,
    input  logic                   spike_valid_i
);

    region_e           region;
    logic [SYN_AW-1:0] syn_word;
    logic [1:0]        param_idx;

    neuron_core_bus_ctrl_addr_dec #(
        .BASE_HI (BASE_HI),
        .SYN_AW  (SYN_AW),
        .N_PARAM (N_PARAM)
    ) u_addr_dec (
        .adr       (wbs_adr_i),
        .region    (region),
        .syn_word  (syn_word),
        .param_idx (param_idx)
    );

    state_e                   state_q, state_d;
    logic [SYN_AW-1:0]        lat_addr_q;
    logic [31:0]              lat_data_q;
    logic [3:0]               lat_sel_q;
    logic                     lat_we_q;
    logic                     ram_rd_q;
    logic [31:0]              rd_data_q;
    logic [31:0]              spike_q;
    logic [N_PARAM-1:0][31:0] param_q;
    logic                     start_q;

    logic req, accept_syn, reg_access, spike_rd, param_wr;

    assign req        = wbs_cyc_i & wbs_stb_i & (state_q == ST_IDLE);
    assign accept_syn = req & (region == REGION_SYN) & ~core_busy_i;
    assign reg_access = req & (region != REGION_SYN);
    assign spike_rd   = reg_access & (region == REGION_SPIKE) & ~wbs_we_i;
    assign param_wr   = reg_access & (region == REGION_PARAM) & wbs_we_i;

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        wbs_ack_o = 1'b0;
        wbs_dat_o = '0;
        ram_en_o  = 1'b0;
        ram_we_o  = 4'h0;
        ram_a_o   = '0;
        ram_di_o  = '0;
        case (state_q)
            ST_IDLE: begin
                if (accept_syn)      state_d = ST_RAM;
                else if (reg_access) state_d = ST_ACK;
            end
            ST_RAM: begin
                state_d  = ST_ACK;
                ram_en_o = 1'b1;
                ram_we_o = lat_we_q ? lat_sel_q : 4'h0;
                ram_a_o  = lat_addr_q;
                ram_di_o = lat_data_q;
            end
            ST_ACK: begin
                state_d   = ST_IDLE;
                wbs_ack_o = wbs_cyc_i;
                // The RAM's own output register holds the fetched word through ACK.
                if (wbs_cyc_i) wbs_dat_o = ram_rd_q ? ram_do_i : rd_data_q;
            end
            default: state_d = ST_IDLE;
        endcase
        if (core_busy_i && state_q != ST_RAM) begin
            ram_en_o = core_rd_i;
            ram_a_o  = core_addr_i;
            ram_we_o = 4'h0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            lat_addr_q <= '0;
            lat_data_q <= '0;
            lat_sel_q  <= 4'h0;
            lat_we_q   <= 1'b0;
            ram_rd_q   <= 1'b0;
            rd_data_q  <= '0;
            spike_q    <= '0;
            start_q    <= 1'b0;
            // NOTE: the parameter file is plain flops, so it is reset like any register (unlike a RAM array).
            param_q    <= '0;
        end else begin
            start_q <= param_wr && param_idx == 2'd0 &&
                       wbs_sel_i[PARAM_START_BIT/8] && wbs_dat_i[PARAM_START_BIT];

            if (accept_syn) begin
                lat_addr_q <= syn_word;
                lat_data_q <= wbs_dat_i;
                lat_sel_q  <= wbs_sel_i;
                lat_we_q   <= wbs_we_i;
                ram_rd_q   <= ~wbs_we_i;
                rd_data_q  <= '0;
            end else if (reg_access) begin
                ram_rd_q  <= 1'b0;
                rd_data_q <= '0;
                if (!wbs_we_i) begin
                    case (region)
                        REGION_PARAM: rd_data_q <= param_q[param_idx];
                        REGION_SPIKE: rd_data_q <= spike_q;
                        default:      rd_data_q <= '0;
                    endcase
                end
            end

            if (param_wr) begin
                for (int b = 0; b < 4; b++) begin
                    if (wbs_sel_i[b]) param_q[param_idx][8*b +: 8] <= wbs_dat_i[8*b +: 8];
                end
                // The start bit only triggers; it is never stored.
                if (param_idx == 2'd0) param_q[0][PARAM_START_BIT] <= 1'b0;
            end

            if (spike_rd)           spike_q <= spike_valid_i ? spike_i : '0;
            else if (spike_valid_i) spike_q <= spike_q | spike_i;
        end
    end

    assign core_start_o = start_q;
    assign param_o      = param_q;

endmodule
